rr_grant_ctrl: RTL and testbench
================================

// Module: rr_grant_ctrl
// PURPOSE
//  Sequential wrapper that closes the loop around the combinational round-robin arbiter.
//  - Drives the arbiter's rotate pointer (req_pnt).
//  - Samples the arbiter's one-hot grant (gnt_in) and registers it.
//  - Holds the grant until the owner signals done, then advances the pointer past the owner.
//  - Sits between N requesters and the arbiter; turns a pure priority rotator into a fair,
//    transaction-holding arbiter.
// PARAMETERS
//  N       8   number of requesters; any N >= 2, power of two not required
//  TIMEOUT 64  max cycles a grant may be held; used only with RR_GRANT_TIMEOUT_EN
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           reset, asynchronous, active-high
//  req      in   N           request vector, one bit per requester
//  gnt_in   in   N           one-hot/zero grant from the arbiter, computed from req and req_pnt
//  done     in   1           owner finished; releases the held grant
//  req_pnt  out  $clog2(N)   rotate pointer to the arbiter (registered)
//  gnt      out  N           registered one-hot grant to requesters
//  gnt_idx  out  $clog2(N)   binary index of the current owner (registered)
//  gnt_vld  out  1           high while a grant is held (== |gnt)
//  err      out  1           sticky protocol error
//  timeout  out  1           one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, rst=1): all outputs and state = 0, FSM = IDLE.
//  FSM states: IDLE, BUSY.
//  IDLE
//  - When |req == 1 and gnt_in is one-hot: gnt <= gnt_in; gnt_idx <= encode(gnt_in); move to BUSY.
//  - Latency: req sampled at edge t, gnt visible after edge t (1 cycle).
//  - done is ignored in IDLE.
//  BUSY
//  - gnt, gnt_idx and req_pnt are held stable.
//  - Changes on other req bits are ignored.
//  - Release condition: done=1, or req[gnt_idx]=0 (owner abandons). Both high at once is a
//    single release.
//  - On release: gnt <= 0; req_pnt <= (gnt_idx == N-1) ? 0 : gnt_idx+1; move to IDLE.
//  Re-arbitration
//  - Exactly one idle (bubble) cycle after each release.
//  - The next grant uses the updated req_pnt, so the released owner has the lowest priority.
//  Pointer width and wrap
//  - Arithmetic is done in $clog2(N) bits.
//  - Wrap to 0 is explicit, so non-power-of-two N never produces pointer values >= N.
//  err (sticky until rst)
//  - Set when gnt_in has more than one bit high.
//  - Set in IDLE when |req==1 and gnt_in==0.
//  - Set when gnt_in contains a bit whose req bit is 0.
//  - No grant is taken in the cycle err is detected.
//  Reset mid-BUSY: grant dropped immediately (async); req_pnt returns to 0.
// CONFIGURATION
//  RR_GRANT_TIMEOUT_EN defined
//  - A counter of $clog2(TIMEOUT+1) bits clears on entry to BUSY and increments every BUSY cycle.
//  - When the count reaches TIMEOUT-1 with no release, a forced release occurs at the next edge.
//  - The forced release advances the pointer as a normal release and pulses timeout for 1 cycle.
//  - A normal release in the same cycle takes precedence; timeout is not pulsed.
//  RR_GRANT_TIMEOUT_EN undefined
//  - No counter logic; timeout tied to 0.
//  - A grant is held indefinitely until done or the owner drops req.
// TESTING (N=8; bench contains the combinational arbiter driven by req/req_pnt)
//  1 Reset/single req
//    - After rst: all outputs 0.
//    - req=8'h10 -> next cycle gnt=8'h10, gnt_idx=4, gnt_vld=1.
//    - done pulse -> gnt=0, req_pnt=5.
//  2 Fair rotation
//    - req=8'hFF held, done every 3rd cycle.
//    - Grant order is idx 0,1,2,...,7,0; one bubble cycle between grants.
//  3 Wrap
//    - Owner idx 7 releases -> req_pnt=0.
//    - With req=8'h81 the next grant is idx 0.
//  4 Hold/abandon
//    - Owner idx 2 busy while req changes to 8'hF0 (req[2] drops).
//    - Release the same cycle; req_pnt=3; next gnt=8'h10.
//    - done and req drop together -> exactly one release.
//  5 Protocol error
//    - Force gnt_in=8'h03 -> err=1, no grant taken.
//    - err stays 1 until rst.
//    - Reset asserted mid-BUSY clears gnt asynchronously.
//  6 Timeout (RR_GRANT_TIMEOUT_EN, TIMEOUT=4)
//    - Owner idx 1 never sends done -> gnt drops after 4 BUSY cycles.
//    - timeout pulses once; req_pnt=2.
//    - Without the macro: grant held >100 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// Transaction-holding round-robin controller wrapped around a combinational rotate arbiter.
// Optional forced release after TIMEOUT held cycles is enabled by defining RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         gnt_in,
    input  logic                 done,
    output logic [$clog2(N)-1:0] req_pnt,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld,
    output logic                 err,
    output logic                 timeout
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   gnt_reg, gnt_next;
    logic [W-1:0]   idx_reg, idx_next;
    logic [W-1:0]   pnt_reg, pnt_next;
    logic           err_reg, err_next;
    logic           timeout_reg, timeout_next;

    logic [W-1:0]   enc;
    logic           multi_hot;
    logic           stray_bit;
    logic           err_det;
    logic           normal_rel;
    logic           forced_rel;

    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_in[i]) begin
                enc = enc | W'(i);
            end
        end
    end

    // A zero grant against live requests only counts as a fault while waiting to arbitrate.
    assign multi_hot  = (gnt_in & (gnt_in - 1'b1)) != '0;
    assign stray_bit  = |(gnt_in & ~req);
    assign err_det    = multi_hot | stray_bit |
                        ((state_reg == IDLE) && (|req) && (gnt_in == '0));
    assign normal_rel = done | ~req[idx_reg];

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_reg, cnt_next;

    assign forced_rel = (state_reg == BUSY) && !normal_rel &&
                        (cnt_reg == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_next = '0;
        if (state_reg == BUSY) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign forced_rel = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        idx_next     = idx_reg;
        pnt_next     = pnt_reg;
        err_next     = err_reg | err_det;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((|req) && !err_det) begin
                    gnt_next   = gnt_in;
                    idx_next   = enc;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Advancing past the owner gives it the lowest priority next round.
                if (normal_rel || forced_rel) begin
                    gnt_next     = '0;
                    pnt_next     = (idx_reg == LAST) ? '0 : idx_reg + 1'b1;
                    timeout_next = forced_rel;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            pnt_reg     <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            idx_reg     <= idx_next;
            pnt_reg     <= pnt_next;
            err_reg     <= err_next;
            timeout_reg <= timeout_next;
        end
    end

    assign req_pnt = pnt_reg;
    assign gnt     = gnt_reg;
    assign gnt_idx = idx_reg;
    assign gnt_vld = |gnt_reg;
    assign err     = err_reg;
    assign timeout = timeout_reg;
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl with N=8 and a behavioural rotate arbiter feeding gnt_in.
module tb_rr_grant_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt_in;
    logic       done = 1'b0;
    logic [2:0] req_pnt;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       err;
    logic       timeout;

    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;
    logic [7:0] arb;
    logic       found;
    int         arb_i;

    int checks = 0;
    int errors = 0;

    rr_grant_ctrl #(.N(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt_in(gnt_in), .done(done),
        .req_pnt(req_pnt), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
        .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        arb   = 8'h00;
        found = 1'b0;
        arb_i = 0;
        for (int k = 0; k < 8; k++) begin
            arb_i = (int'(req_pnt) + k) % 8;
            if (!found && req[arb_i]) begin
                arb[arb_i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_in = force_en ? force_val : arb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00; done = 1'b0; force_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, gnt_idx, req_pnt, gnt_vld, err, timeout} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%h idx=%0d pnt=%0d vld=%b err=%b to=%b, need all 0",
                     gnt, gnt_idx, req_pnt, gnt_vld, err, timeout);
        end
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gnt=%h idx=%0d vld=%b, need 10/4/1", gnt, gnt_idx, gnt_vld);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || req_pnt !== 3'd5) begin
            errors++;
            $display("FAIL single_release: got gnt=%h pnt=%0d, need 00/5", gnt, req_pnt);
        end
        $display("test_reset: done");
    endtask

    task automatic test_rotation();
        logic [7:0] exp_gnt;
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            exp_gnt = 8'h01 << (g % 8);
            tick();
            checks++;
            if (gnt !== exp_gnt || gnt_idx !== 3'(g % 8)) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: got gnt=%h idx=%0d, need %h/%0d",
                         g, gnt, gnt_idx, exp_gnt, g % 8);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== 8'h00 || req_pnt !== 3'((g + 1) % 8)) begin
                errors++;
                $display("FAIL rotation_bubble[%0d]: got gnt=%h pnt=%0d, need 00/%0d",
                         g, gnt, req_pnt, (g + 1) % 8);
            end
        end
        req = 8'h00;
        $display("test_rotation: done");
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h80;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (req_pnt !== 3'd0 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pointer: got pnt=%0d gnt=%h, need 0/00", req_pnt, gnt);
        end
        req = 8'h81;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL wrap_grant: got gnt=%h idx=%0d, need 01/0", gnt, gnt_idx);
        end
        $display("test_wrap: done");
    endtask

    task automatic test_abandon();
        do_reset();
        req = 8'h04;
        tick();
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
            errors++;
            $display("FAIL abandon_grant: got gnt=%h idx=%0d, need 04/2", gnt, gnt_idx);
        end
        req = 8'hF0;
        tick();
        checks++;
        if (gnt !== 8'h00 || req_pnt !== 3'd3) begin
            errors++;
            $display("FAIL abandon_release: got gnt=%h pnt=%0d, need 00/3", gnt, req_pnt);
        end
        tick();
        checks++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
            errors++;
            $display("FAIL abandon_regrant: got gnt=%h idx=%0d, need 10/4", gnt, gnt_idx);
        end
        done = 1'b1;
        req  = 8'hE0;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || req_pnt !== 3'd5) begin
            errors++;
            $display("FAIL dual_release: got gnt=%h pnt=%0d, need 00/5", gnt, req_pnt);
        end
        tick();
        checks++;
        if (gnt !== 8'h20 || req_pnt !== 3'd5) begin
            errors++;
            $display("FAIL dual_regrant: got gnt=%h pnt=%0d, need 20/5", gnt, req_pnt);
        end
        $display("test_abandon: done");
    endtask

    task automatic test_protocol_error();
        do_reset();
        req = 8'h03; force_en = 1'b1; force_val = 8'h03;
        tick();
        checks++;
        if (err !== 1'b1 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL err_multihot: got err=%b gnt=%h, need 1/00", err, gnt);
        end
        force_en = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1 || gnt !== 8'h01) begin
            errors++;
            $display("FAIL err_sticky: got err=%b gnt=%h, need 1/01", err, gnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0 || req_pnt !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%h vld=%b pnt=%0d err=%b, need 00/0/0/0",
                     gnt, gnt_vld, req_pnt, err);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'h01; force_en = 1'b1; force_val = 8'h04;
        tick();
        force_en = 1'b0;
        checks++;
        if (err !== 1'b1 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL err_stray: got err=%b gnt=%h, need 1/00", err, gnt);
        end
        $display("test_protocol_error: done");
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h02;
        tick();
        checks++;
        if (gnt !== 8'h02 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_grant: got gnt=%h to=%b, need 02/0", gnt, timeout);
        end
`ifdef RR_GRANT_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h02 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: got gnt=%h to=%b, need 02/0", c, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || req_pnt !== 3'd2) begin
            errors++;
            $display("FAIL timeout_fire: got gnt=%h to=%b pnt=%0d, need 00/1/2", gnt, timeout, req_pnt);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got to=%b, need 0", timeout);
        end
`else
        for (int c = 1; c < 110; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h02 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_forever[%0d]: got gnt=%h to=%b, need 02/0", c, gnt, timeout);
            end
        end
`endif
        $display("test_timeout: done");
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_abandon();
        test_protocol_error();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
